// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: types shared by the pulse former and its helpers.
//   pg_state_t : pulse former FSM state (IDLE / ON / OFF)
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } pg_state_t;

endpackage

// File: rtl/pulse_gen_tick_prescaler.sv
// tick_prescaler: free-running clock divider producing a one-clock tick
// every prescale+1 clocks. A restart forces the timer back to zero so
// the caller can align tick boundaries to its own events.
//   clk      in  system clock
//   aclr     in  async reset, active-high
//   sclr     in  sync clear
//   restart  in  zero the timer on the next edge
//   prescale in  compare value; tick when timer == prescale
//   tick     out high while timer == prescale
module tick_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic                      sclr,
    input  logic                      restart,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] timer;

    assign tick = (timer == prescale);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            timer <= '0;
        end else if (sclr || restart || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: EDM generator pulse former. Drives the generator switch with
// repeating ON/OFF pulses while enabled, with widths in prescaled ticks.
// A short-circuit truncates the current pulse; every stop is followed by a
// full off-time so the switch never re-fires without a pause.
//   clk        in  system clock
//   aclr       in  async reset, active-high
//   sclr       in  sync clear, same effect as aclr on next edge
//   enabled    in  generator permitted
//   short_det  in  short-circuit detect (synchronous)
//   prescale   in  tick = prescale+1 clocks
//   ton        in  ON time in ticks (0 = never fire)
//   toff       in  OFF time in ticks (0 treated as 1)
//   pulse      out switch drive, registered
//   busy       out state != IDLE
//   pulse_cnt  out ON entries since reset, wraps
//   short_cnt  out short-truncated pulses since reset, wraps
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16,
    parameter int WIDTH          = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic                      sclr,
    input  logic                      enabled,
    input  logic                      short_det,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          ton,
    input  logic [WIDTH-1:0]          toff,
    output logic                      pulse,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      pulse_cnt,
    output logic [CNT_WIDTH-1:0]      short_cnt
);

    pg_state_t                 state;
    pg_state_t                 next_state;
    logic                      short_hit;
    logic                      restart;
    logic                      enter_on;
    logic                      tick;
    logic [WIDTH-1:0]          tick_cnt;
    logic [WIDTH-1:0]          ton_sh;
    logic [WIDTH-1:0]          toff_sh;
    logic [PRESCALE_WIDTH-1:0] prescale_sh;
    logic [WIDTH-1:0]          ton_last;
    logic [WIDTH-1:0]          toff_last;

    // Shadow values are only consulted in ON/OFF, and ON is only entered
    // with ton != 0, so ton_sh - 1 never underflows where it matters.
    assign ton_last  = ton_sh - WIDTH'(1);
    assign toff_last = (toff_sh == '0) ? '0 : toff_sh - WIDTH'(1);

    tick_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .aclr     (aclr),
        .sclr     (sclr),
        .restart  (restart),
        .prescale (prescale_sh),
        .tick     (tick)
    );

    always_comb begin
        next_state = state;
        short_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (enabled && (ton != '0)) begin
                    next_state = ON;
                end
            end
            ON: begin
                // A short wins over a coinciding end-of-pulse tick so it is counted.
                if (short_det) begin
                    next_state = OFF;
                    short_hit  = 1'b1;
                end else if (!enabled || (tick && (tick_cnt == ton_last))) begin
                    next_state = OFF;
                end
            end
            OFF: begin
                if (tick && (tick_cnt == toff_last)) begin
                    next_state = (enabled && (ton != '0)) ? ON : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Every state change restarts timing so each phase gets exact durations.
    assign restart  = (next_state != state);
    assign enter_on = (next_state == ON) && (state != ON);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            pulse     <= 1'b0;
            tick_cnt  <= '0;
            pulse_cnt <= '0;
            short_cnt <= '0;
        end else if (sclr) begin
            state     <= IDLE;
            pulse     <= 1'b0;
            tick_cnt  <= '0;
            pulse_cnt <= '0;
            short_cnt <= '0;
        end else begin
            state <= next_state;
            pulse <= (next_state == ON);
            if (restart) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + WIDTH'(1);
            end
            if (enter_on) begin
                pulse_cnt <= pulse_cnt + CNT_WIDTH'(1);
            end
            if (short_hit) begin
                short_cnt <= short_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Timing parameters are frozen for a whole ON/OFF period.
    always_ff @(posedge clk) begin
        if (enter_on) begin
            ton_sh      <= ton;
            toff_sh     <= toff;
            prescale_sh <= prescale;
        end
    end

endmodule
